// File: rtl/compare_iter_unit.sv
// Iterative comparator: scans operands one CHUNK at a time from the MSB end,
// stopping at the first differing chunk, and holds the result until consumed.
module compare_iter_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             err,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [KW-1:0]    r_k;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_result;
  logic             r_err;
  logic             r_busy;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_lt;
  logic             w_eq;
  logic             w_last;
  logic             w_res;
  logic             w_err;

  // Chunk 0 carries the sign; flipping its MSB turns a signed compare into
  // an unsigned one, so every chunk can use the same magnitude compare.
  always_comb begin
    w_ca = '0;
    w_cb = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_k == KW'(i)) begin
        w_ca = r_a[WIDTH-1-i*CHUNK -: CHUNK];
        w_cb = r_b[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
    if (r_k == '0 && (r_op == 3'b000 || r_op == 3'b100)) begin
      w_ca[CHUNK-1] = ~w_ca[CHUNK-1];
      w_cb[CHUNK-1] = ~w_cb[CHUNK-1];
    end
  end

  // Scanning stops at the first difference, so a chunk match here implies
  // every earlier chunk matched too.
  assign w_lt   = (w_ca < w_cb);
  assign w_eq   = (w_ca == w_cb);
  assign w_last = (r_k == KW'(N - 1));

  always_comb begin
    w_res = 1'b0;
    w_err = 1'b0;
    case (r_op)
      3'b000, 3'b001: w_res = w_lt;
      3'b010:         w_res = w_eq;
      3'b011:         w_res = ~w_eq;
      3'b100, 3'b101: w_res = ~w_lt;
      default:        w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_eq || w_last) begin
            r_result    <= w_res;
            r_err       <= w_err;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_compare_iter_unit.sv
// Directed bench for compare_iter_unit (WIDTH=64, CHUNK=16) with
// hand-computed results and latencies.
module tb_compare_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic        result;
  logic        err;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  compare_iter_unit #(.WIDTH(64), .CHUNK(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one request, measure latency, optionally stall in DONE, then drain.
  task automatic run(input string tag, input logic [63:0] va, input logic [63:0] vb,
                     input logic [2:0] vop, input logic exp_res, input logic exp_err,
                     input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~va; b = ~vb; op = 3'b010;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".result"}, 64'(result), 64'(exp_res));
    check({tag, ".err"}, 64'(err), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_result"}, 64'(result), 64'(exp_res));
      check({tag, ".hold_err"}, 64'(err), 64'(exp_err));
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".in_ready_post"}, 64'(in_ready), 64'd1);
    check({tag, ".busy_post"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.result", 64'(result), 64'd0);
    check("reset.err", 64'(err), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);

    run("sltu_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b001, 1'b0, 1'b0, 1, 0);
    run("slt_max",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 1'b1, 1'b0, 1, 0);
    run("slt_30_15", 64'd30, 64'd15, 3'b000, 1'b0, 1'b0, 4, 0);
    run("geu_30_15", 64'd30, 64'd15, 3'b101, 1'b1, 1'b0, 4, 0);
    run("eq_25", 64'd25, 64'd25, 3'b010, 1'b1, 1'b0, 4, 0);
    run("ne_25", 64'd25, 64'd25, 3'b011, 1'b0, 1'b0, 4, 0);
    run("ge_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 1'b0, 1'b0, 1, 0);
    run("ne_k2", 64'h0000_0000_0001_0000, 64'd0, 3'b011, 1'b1, 1'b0, 3, 0);
    run("eq_k1", 64'h0000_0001_0000_0000, 64'd0, 3'b010, 1'b0, 1'b0, 2, 0);
    run("geu_3_7", 64'd3, 64'd7, 3'b101, 1'b0, 1'b0, 4, 0);
    run("slt_m2_m1", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b1, 1'b0, 4, 0);
    run("backpressure", 64'd30, 64'd15, 3'b000, 1'b0, 1'b0, 4, 5);
    run("illegal_110", 64'd5, 64'd5, 3'b110, 1'b0, 1'b1, 4, 0);
    run("illegal_111", 64'h8000_0000_0000_0000, 64'd0, 3'b111, 1'b0, 1'b1, 1, 0);
    run("legal_after", 64'd5, 64'd9, 3'b001, 1'b1, 1'b0, 4, 0);

    // Abort a 4-cycle scan while chunk 1 is being compared.
    @(negedge clk);
    a = 64'd30; b = 64'd15; op = 3'b000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.busy", 64'(busy), 64'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("abort.no_valid", 64'(seen), 64'd0);
    run("after_abort", 64'd30, 64'd15, 3'b101, 1'b1, 1'b0, 4, 0);

    // Reset wins over a simultaneous acceptance.
    @(negedge clk);
    a = 64'd1; b = 64'd2; op = 3'b001; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_prio.busy", 64'(busy), 64'd0);
    check("rst_prio.in_ready", 64'(in_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("rst_prio.no_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
